reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter_pkg.sv | 9 +
 rtl/mod_register.sv | 20 ++
 rtl/reg_share_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// rtl/reg_share_arbiter_pkg.sv - shared controller encodings for the register-sharing arbiter
package reg_share_arbiter_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/mod_register.sv
// rtl/mod_register.sv - generic enabled register with synchronous active-high clear
module mod_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - N-way round-robin arbiter with burst lock feeding one holding register
module reg_share_arbiter
    import reg_share_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_src,
    input  logic                 out_ready,
    output logic                 locked
);

    localparam int SW = $clog2(N);

    lock_state_t         state;
    lock_state_t         state_next;
    logic [SW-1:0]       ptr;
    logic [SW-1:0]       gnt;
    logic [SW-1:0]       cand;
    logic                gnt_found;
    logic                gnt_last;
    logic                accept;
    logic                xfer;
    logic [WIDTH-1:0]    sel_data;
    logic [SW+WIDTH-1:0] hold_d;
    logic [SW+WIDTH-1:0] hold_q;

    assign accept = !out_valid || out_ready;
    assign locked = (state == LOCKED);

    // While locked, ptr already holds the burst owner, so no separate lock index is kept.
    always_comb begin
        gnt       = ptr;
        gnt_found = 1'b0;
        cand      = '0;
        if (state == LOCKED) begin
            gnt_found = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = SW'((int'(ptr) + k) % N);
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt       = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && accept && gnt_found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign gnt_last = req_last[gnt];

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SW'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign hold_d = {gnt, sel_data};

    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: if (xfer && !gnt_last) state_next = LOCKED;
            LOCKED:   if (xfer && gnt_last)  state_next = UNLOCKED;
            default:  state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNLOCKED;
            ptr   <= SW'(N - 1);
        end else begin
            state <= state_next;
            if (xfer) begin
                ptr <= gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    mod_register #(
        .WIDTH(SW + WIDTH)
    ) u_hold (
        .clk(clk),
        .rst(rst),
        .en (xfer),
        .d  (hold_d),
        .q  (hold_q)
    );

    assign {out_src, out_data} = hold_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        out_src;
    logic              out_ready;
    logic              locked;

    reg_share_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       o;
        logic [3:0] rdy;
        logic       lock;
    } vec_t;

    vec_t        tbl[16];
    logic [17:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          seq    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled mid-cycle.
    task automatic run_cycle(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d,
                             input logic o, input logic [3:0] rdy, input logic lock);
        logic [17:0] e;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        out_ready = o;
        #3;
        chk("req_ready", {28'd0, req_ready & req_valid}, {28'd0, rdy});
        chk("locked", {31'd0, locked}, {31'd0, lock});
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        if (out_valid && o && sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_src", {30'd0, out_src}, {30'd0, e[17:16]});
            chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
        end
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) sb.push_back({2'(i), d[i*16 +: 16]});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_data(input int s);
        logic [63:0] d;
        for (int i = 0; i < N; i++) d[i*16 +: 16] = {4'(i), 12'(s)};
        return d;
    endfunction

    initial begin
        logic [63:0] d;

        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0};
        tbl[5]  = '{4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b0};
        tbl[6]  = '{4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b1};
        tbl[7]  = '{4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[8]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0};
        tbl[10] = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b1};
        tbl[11] = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1};
        tbl[12] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0};
        tbl[13] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[15] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #3;
        chk("reset_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {16'd0, out_data}, 32'd0);
        chk("reset_out_src", {30'd0, out_src}, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        rst = 1'b0;

        for (int t = 0; t < 16; t++) begin
            seq++;
            run_cycle(tbl[t].v, tbl[t].l, mk_data(seq), tbl[t].o, tbl[t].rdy, tbl[t].lock);
        end

        run_cycle(4'b0000, 4'b0000, mk_data(100), 1'b1, 4'b0000, 1'b0);
        d = mk_data(101);
        d[47:32] = 16'hA5A5;
        run_cycle(4'b0100, 4'b0100, d, 1'b1, 4'b0100, 1'b0);
        chk("bp_data_load", {16'd0, out_data}, 32'h0000A5A5);
        for (int k = 0; k < 3; k++) begin
            run_cycle(4'b0100, 4'b0100, mk_data(102 + k), 1'b0, 4'b0000, 1'b0);
            chk("bp_data_hold", {16'd0, out_data}, 32'h0000A5A5);
            chk("bp_src_hold", {30'd0, out_src}, 32'd2);
        end
        run_cycle(4'b0000, 4'b0000, mk_data(110), 1'b1, 4'b0000, 1'b0);

        run_cycle(4'b1000, 4'b0000, mk_data(120), 1'b1, 4'b1000, 1'b0);
        req_valid = 4'b1110;
        req_last  = 4'b1110;
        rst       = 1'b1;
        #3;
        chk("midburst_rst_ready", {28'd0, req_ready & req_valid}, 32'd0);
        chk("midburst_locked_before", {31'd0, locked}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("midburst_locked_after", {31'd0, locked}, 32'd0);
        chk("midburst_out_valid", {31'd0, out_valid}, 32'd0);
        run_cycle(4'b1110, 4'b1110, mk_data(121), 1'b1, 4'b0010, 1'b0);
        run_cycle(4'b0000, 4'b0000, mk_data(122), 1'b1, 4'b0000, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
